// File: rtl/network_interface.sv
// Mesh network interface: packetises PE requests toward the router and buffers
// router deliveries in a small first-word-fall-through FIFO for the PE.

package pa_noc;
  localparam int unsigned PACKET_WIDTH = 16;
  localparam int unsigned COORD_W      = 2;

  typedef struct packed {
    logic [PACKET_WIDTH-9:0] payload;
    logic [COORD_W-1:0]      src_row;
    logic [COORD_W-1:0]      src_col;
    logic [COORD_W-1:0]      dst_row;
    logic [COORD_W-1:0]      dst_col;
  } packet_t;
endpackage

module network_interface
  import pa_noc::*;
#(
  parameter int unsigned GRID_WIDTH    = 4,
  parameter int unsigned ROUTER_ROW    = 0,
  parameter int unsigned ROUTER_COL    = 0,
  parameter int unsigned RX_FIFO_DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_arst_n,
  input  logic [PACKET_WIDTH-9:0]  i_txPayload,
  input  logic [$clog2(GRID_WIDTH)-1:0] i_txDstRow,
  input  logic [$clog2(GRID_WIDTH)-1:0] i_txDstCol,
  input  logic                     i_txValid,
  output logic                     o_txReady,
  output logic [PACKET_WIDTH-1:0]  o_router,
  output logic                     o_routerValid,
  input  logic                     i_routerReady,
  input  logic [PACKET_WIDTH-1:0]  i_router,
  input  logic                     i_routerValid,
  output logic                     o_routerReady,
  output logic [PACKET_WIDTH-9:0]  o_rxPayload,
  output logic [$clog2(GRID_WIDTH)-1:0] o_rxSrcRow,
  output logic [$clog2(GRID_WIDTH)-1:0] o_rxSrcCol,
  output logic                     o_rxValid,
  input  logic                     i_rxReady,
  output logic [15:0]              o_txCount,
  output logic [15:0]              o_rxCount,
  output logic                     o_rxOverflow
);

  localparam int unsigned PAYLOAD_WIDTH = PACKET_WIDTH - 8;
  localparam int unsigned PTR_W         = $clog2(RX_FIFO_DEPTH);
  localparam int unsigned CNT_W         = PTR_W + 1;

  typedef enum logic {IDLE, SEND} tx_state_e;

  tx_state_e           state_q, state_d;
  packet_t             pkt_q, pkt_d;
  packet_t             new_pkt;
  logic [15:0]         tx_count_q, tx_count_d;
  logic                tx_ready;

  packet_t             mem_q [RX_FIFO_DEPTH];
  packet_t             mem_d [RX_FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                ready_q, ready_d;
  logic                ovf_q, ovf_d;
  logic [15:0]         rx_count_q, rx_count_d;
  logic                rx_valid, push, pop, full, wr_en, router_ready;
  packet_t             head;

  // TX request packetisation and send handshake
  always_comb begin
    state_d    = state_q;
    pkt_d      = pkt_q;
    tx_count_d = tx_count_q;
    tx_ready   = 1'b0;

    new_pkt         = '0;
    new_pkt.payload = PAYLOAD_WIDTH'(i_txPayload);
    new_pkt.src_row = COORD_W'(ROUTER_ROW);
    new_pkt.src_col = COORD_W'(ROUTER_COL);
    new_pkt.dst_row = COORD_W'(i_txDstRow);
    new_pkt.dst_col = COORD_W'(i_txDstCol);

    case (state_q)
      IDLE: begin
        tx_ready = 1'b1;
        if (i_txValid) begin
          pkt_d   = new_pkt;
          state_d = SEND;
        end
      end
      SEND: begin
        if (i_routerReady) begin
          tx_ready   = 1'b1;
          tx_count_d = tx_count_q + 16'd1;
          if (i_txValid) begin
            pkt_d = new_pkt;
          end else begin
            // Packet register is cleared so o_router reads zero while idle
            pkt_d   = '0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        pkt_d   = '0;
      end
    endcase
  end

  // RX FIFO: beats arriving while the previous-cycle ready was low are router resends
  always_comb begin
    rx_valid     = (count_q != '0);
    pop          = rx_valid && i_rxReady;
    push         = i_routerValid && ready_q;
    full         = (count_q == CNT_W'(RX_FIFO_DEPTH));
    wr_en        = push && !full;
    router_ready = (count_q <= CNT_W'(RX_FIFO_DEPTH - 2));

    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    rx_count_d = rx_count_q;
    ready_d    = router_ready;
    ovf_d      = ovf_q | (push && full);

    if (wr_en) begin
      mem_d[wr_ptr_q] = packet_t'(i_router);
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d   = rd_ptr_q + PTR_W'(1);
      rx_count_d = rx_count_q + 16'd1;
    end
    count_d = count_q + CNT_W'(wr_en) - CNT_W'(pop);
    head    = mem_q[rd_ptr_q];
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q    <= IDLE;
      pkt_q      <= '0;
      tx_count_q <= '0;
      mem_q      <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ready_q    <= 1'b0;
      ovf_q      <= 1'b0;
      rx_count_q <= '0;
    end else begin
      state_q    <= state_d;
      pkt_q      <= pkt_d;
      tx_count_q <= tx_count_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ready_q    <= ready_d;
      ovf_q      <= ovf_d;
      rx_count_q <= rx_count_d;
    end
  end

  assign o_txReady     = tx_ready;
  assign o_router      = pkt_q;
  assign o_routerValid = (state_q == SEND);
  assign o_txCount     = tx_count_q;
  assign o_routerReady = router_ready;
  assign o_rxValid     = rx_valid;
  assign o_rxPayload   = head.payload;
  assign o_rxSrcRow    = head.src_row;
  assign o_rxSrcCol    = head.src_col;
  assign o_rxCount     = rx_count_q;
  assign o_rxOverflow  = ovf_q;

endmodule

// File: tb/tb_network_interface.sv
// Directed bench for network_interface with a transaction-level queue model
// checked every cycle, plus literal expectations pinning key results.

module tb_network_interface;
  import pa_noc::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned MY_ROW = 1;
  localparam int unsigned MY_COL = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  i_txPayload = '0;
  logic [1:0]  i_txDstRow = '0, i_txDstCol = '0;
  logic        i_txValid = 1'b0;
  logic        o_txReady;
  logic [15:0] o_router;
  logic        o_routerValid;
  logic        i_routerReady = 1'b0;
  logic [15:0] i_router = '0;
  logic        i_routerValid = 1'b0;
  logic        o_routerReady;
  logic [7:0]  o_rxPayload;
  logic [1:0]  o_rxSrcRow, o_rxSrcCol;
  logic        o_rxValid;
  logic        i_rxReady = 1'b0;
  logic [15:0] o_txCount, o_rxCount;
  logic        o_rxOverflow;

  network_interface #(
    .GRID_WIDTH(4), .ROUTER_ROW(MY_ROW), .ROUTER_COL(MY_COL), .RX_FIFO_DEPTH(DEPTH)
  ) dut (
    .i_clk(clk), .i_arst_n(rst_n),
    .i_txPayload(i_txPayload), .i_txDstRow(i_txDstRow), .i_txDstCol(i_txDstCol),
    .i_txValid(i_txValid), .o_txReady(o_txReady),
    .o_router(o_router), .o_routerValid(o_routerValid), .i_routerReady(i_routerReady),
    .i_router(i_router), .i_routerValid(i_routerValid), .o_routerReady(o_routerReady),
    .o_rxPayload(o_rxPayload), .o_rxSrcRow(o_rxSrcRow), .o_rxSrcCol(o_rxSrcCol),
    .o_rxValid(o_rxValid), .i_rxReady(i_rxReady),
    .o_txCount(o_txCount), .o_rxCount(o_rxCount), .o_rxOverflow(o_rxOverflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state: packets accepted but not yet taken by the router, packets buffered for the PE
  logic [15:0] tq[$];
  logic [15:0] rq[$];
  int          txc = 0;
  int          rxc = 0;
  bit          ovf = 0;
  bit          prev_rdy = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_cycle();
    logic [15:0] h;
    logic [15:0] exp_router;
    bit e_txr, e_rdy, wr, full_pre;
    if (!rst_n) begin
      tq.delete(); rq.delete();
      txc = 0; rxc = 0; ovf = 0; prev_rdy = 0;
      cmp("rst_txReady",     32'(o_txReady), 1);
      cmp("rst_routerValid", 32'(o_routerValid), 0);
      cmp("rst_router",      32'(o_router), 0);
      cmp("rst_routerReady", 32'(o_routerReady), 1);
      cmp("rst_rxValid",     32'(o_rxValid), 0);
      cmp("rst_txCount",     32'(o_txCount), 0);
      cmp("rst_rxCount",     32'(o_rxCount), 0);
      cmp("rst_overflow",    32'(o_rxOverflow), 0);
      return;
    end
    e_txr = (tq.size() == 0) || i_routerReady;
    e_rdy = (rq.size() <= DEPTH - 2);
    exp_router = (tq.size() != 0) ? tq[0] : 16'h0;
    cmp("m_txReady",     32'(o_txReady), 32'(e_txr));
    cmp("m_routerValid", 32'(o_routerValid), 32'(tq.size() != 0));
    cmp("m_router",      32'(o_router), 32'(exp_router));
    cmp("m_routerReady", 32'(o_routerReady), 32'(e_rdy));
    cmp("m_rxValid",     32'(o_rxValid), 32'(rq.size() != 0));
    if (rq.size() != 0) begin
      h = rq[0];
      cmp("m_rxPayload", 32'(o_rxPayload), 32'(h[15:8]));
      cmp("m_rxSrcRow",  32'(o_rxSrcRow), 32'(h[7:6]));
      cmp("m_rxSrcCol",  32'(o_rxSrcCol), 32'(h[5:4]));
    end
    cmp("m_txCount",  32'(o_txCount), 32'(txc));
    cmp("m_rxCount",  32'(o_rxCount), 32'(rxc));
    cmp("m_overflow", 32'(o_rxOverflow), 32'(ovf));

    if (tq.size() != 0 && i_routerReady) begin
      void'(tq.pop_front());
      txc = (txc + 1) % 65536;
    end
    if (i_txValid && e_txr)
      tq.push_back(16'(int'(i_txPayload) * 256 + MY_ROW * 64 + MY_COL * 16 +
                       int'(i_txDstRow) * 4 + int'(i_txDstCol)));
    wr = i_routerValid && prev_rdy;
    full_pre = (rq.size() == DEPTH);
    if (rq.size() != 0 && i_rxReady) begin
      void'(rq.pop_front());
      rxc = (rxc + 1) % 65536;
    end
    if (wr) begin
      if (full_pre) ovf = 1;
      else rq.push_back(i_router);
    end
    prev_rdy = e_rdy;
  endtask

  task automatic step();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    step(); step();
    rst_n = 1'b1;
    step();

    // Single packet to (3,0) from router (1,2)
    i_txPayload = 8'hA5; i_txDstRow = 2'd3; i_txDstCol = 2'd0;
    i_txValid = 1'b1; i_routerReady = 1'b1;
    step();
    cmp("t1_valid", 32'(o_routerValid), 1);
    cmp("t1_router", 32'(o_router), 32'h0000A56C);
    i_txValid = 1'b0;
    step();
    cmp("t1_valid_drop", 32'(o_routerValid), 0);
    cmp("t1_txCount", 32'(o_txCount), 1);

    // Router stalls five cycles during SEND
    i_routerReady = 1'b0;
    i_txPayload = 8'h3C; i_txDstRow = 2'd0; i_txDstCol = 2'd2; i_txValid = 1'b1;
    step();
    i_txValid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      cmp("t2_router_held", 32'(o_router), 32'h00003C62);
      cmp("t2_txReady_low", 32'(o_txReady), 0);
    end
    i_routerReady = 1'b1;
    step();
    cmp("t2_valid_drop", 32'(o_routerValid), 0);
    cmp("t2_txCount", 32'(o_txCount), 2);

    // Back-to-back sends, one per cycle
    for (int i = 0; i < 8; i++) begin
      i_txPayload = 8'(i + 1); i_txDstRow = 2'(i / 2); i_txDstCol = 2'(i);
      i_txValid = 1'b1;
      step();
    end
    i_txValid = 1'b0;
    step();
    cmp("t5_txCount", 32'(o_txCount), 10);
    cmp("t5_idle", 32'(o_routerValid), 0);

    // Router streams four beats into a PE that is not reading
    i_rxReady = 1'b0;
    for (int i = 0; i < 4; i++) begin
      i_router = 16'(((16 + i) * 256) + (i * 64) + ((3 - i) * 16) + 6);
      i_routerValid = 1'b1;
      step();
    end
    cmp("t3_routerReady", 32'(o_routerReady), 0);
    cmp("t3_rxValid", 32'(o_rxValid), 1);
    cmp("t3_overflow", 32'(o_rxOverflow), 0);
    cmp("t3_head_payload", 32'(o_rxPayload), 32'h10);
    cmp("t3_head_srcRow", 32'(o_rxSrcRow), 0);
    cmp("t3_head_srcCol", 32'(o_rxSrcCol), 3);

    // Resent beat while previous ready was low must be dropped
    i_router = 16'hEEEE;
    step();
    i_routerValid = 1'b0;
    step();
    cmp("t4_overflow", 32'(o_rxOverflow), 0);
    i_rxReady = 1'b1;
    for (int i = 0; i < 4; i++) step();
    cmp("t4_rxCount", 32'(o_rxCount), 4);
    cmp("t4_empty", 32'(o_rxValid), 0);

    // Reset mid-SEND with two RX entries buffered
    i_rxReady = 1'b0; i_routerReady = 1'b0;
    i_txPayload = 8'h77; i_txDstRow = 2'd2; i_txDstCol = 2'd2; i_txValid = 1'b1;
    i_router = 16'h1234; i_routerValid = 1'b1;
    step();
    i_txValid = 1'b0; i_router = 16'h5678;
    step();
    i_routerValid = 1'b0;
    cmp("t6_pre_rxValid", 32'(o_rxValid), 1);
    rst_n = 1'b0;
    #1;
    cmp("t6_routerValid", 32'(o_routerValid), 0);
    cmp("t6_rxValid", 32'(o_rxValid), 0);
    cmp("t6_txCount", 32'(o_txCount), 0);
    cmp("t6_rxCount", 32'(o_rxCount), 0);
    cmp("t6_txReady", 32'(o_txReady), 1);
    step();
    rst_n = 1'b1;
    step();

    // Loopback send after reset
    i_routerReady = 1'b1;
    i_txPayload = 8'h5A; i_txDstRow = 2'd1; i_txDstCol = 2'd2; i_txValid = 1'b1;
    step();
    cmp("t7_router", 32'(o_router), 32'h00005A66);
    i_txValid = 1'b0;
    step();
    step();
    cmp("t7_txCount", 32'(o_txCount), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
